tdm_joiner: RTL

- Receive-side counterpart of the four-channel time-division splitter.
- Consumes the 8-bit serialised sample stream plus the same `holder` enable, and tracks the identical slot schedule: slot0 = 143, slot1 = 110, slot2 = 77, slot3 = 44 samples, 374 samples per frame.
- Demultiplexes each sample to its channel register, pulses a per-channel strobe, and reports per-channel activity and frame count to downstream consumers (DAC/audio mixers).

---
 rtl/tdm_joiner.sv | 118 +++++++++++
 1 files changed

// File: rtl/tdm_joiner.sv
// Receive side of the four-slot TDM link: tracks the splitter's slot schedule,
// demultiplexes each sample to its channel and reports per-channel activity.
module tdm_joiner #(
  parameter int DW   = 8,
  parameter int LEN0 = 143,
  parameter int LEN1 = 110,
  parameter int LEN2 = 77,
  parameter int LEN3 = 44,
  parameter int FCW  = 16
) (
  input  logic           sysclk,
  input  logic           reset_n,
  input  logic           holder,
  input  logic [DW-1:0]  currentData,
  output logic [DW-1:0]  ch0_data,
  output logic [DW-1:0]  ch1_data,
  output logic [DW-1:0]  ch2_data,
  output logic [DW-1:0]  ch3_data,
  output logic [3:0]     ch_stb,
  output logic [1:0]     slot,
  output logic [7:0]     sample_idx,
  output logic           slot_done,
  output logic           frame_done,
  output logic [3:0]     ch_active,
  output logic [FCW-1:0] frame_cnt
);

  // Stream handshake: holder acts as the valid of a stream whose data arrives
  // one cycle later (hold_d). There is no ready; a sample is accepted on every
  // cycle hold_d is high and nothing can stall the source.

  localparam logic [7:0] LAST0 = 8'(LEN0 - 1);
  localparam logic [7:0] LAST1 = 8'(LEN1 - 1);
  localparam logic [7:0] LAST2 = 8'(LEN2 - 1);
  localparam logic [7:0] LAST3 = 8'(LEN3 - 1);

  logic       hold_d;
  logic [1:0] s;
  logic [7:0] idx;
  logic [3:0] nz;

  logic [7:0] last_idx;
  logic       at_last;
  logic       sample_nz;
  logic [3:0] s_onehot;

  always_comb begin
    last_idx = LAST0;
    case (s)
      2'd0:    last_idx = LAST0;
      2'd1:    last_idx = LAST1;
      2'd2:    last_idx = LAST2;
      default: last_idx = LAST3;
    endcase
    at_last   = (idx == last_idx);
    sample_nz = |currentData;
    s_onehot  = 4'b0001 << s;
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      hold_d     <= 1'b0;
      s          <= 2'd0;
      idx        <= 8'd0;
      nz         <= 4'd0;
      ch0_data   <= '0;
      ch1_data   <= '0;
      ch2_data   <= '0;
      ch3_data   <= '0;
      ch_stb     <= 4'd0;
      slot       <= 2'd0;
      sample_idx <= 8'd0;
      slot_done  <= 1'b0;
      frame_done <= 1'b0;
      ch_active  <= 4'd0;
      frame_cnt  <= '0;
    end else begin
      hold_d <= holder;
      if (hold_d) begin
        case (s)
          2'd0:    ch0_data <= currentData;
          2'd1:    ch1_data <= currentData;
          2'd2:    ch2_data <= currentData;
          default: ch3_data <= currentData;
        endcase
        ch_stb     <= s_onehot;
        slot       <= s;
        sample_idx <= idx;
        if (at_last) begin
          // Slot complete: publish its activity and start the next slot clean.
          idx          <= 8'd0;
          s            <= s + 2'd1;
          slot_done    <= 1'b1;
          ch_active[s] <= nz[s] | sample_nz;
          nz[s]        <= 1'b0;
          frame_done   <= (s == 2'd3);
          if (s == 2'd3) begin
            frame_cnt <= frame_cnt + FCW'(1);
          end
        end else begin
          idx        <= idx + 8'd1;
          nz[s]      <= nz[s] | sample_nz;
          slot_done  <= 1'b0;
          frame_done <= 1'b0;
        end
      end else begin
        // Source restarts at slot 0 when re-enabled, so partial progress is dropped.
        s          <= 2'd0;
        idx        <= 8'd0;
        nz         <= 4'd0;
        ch_stb     <= 4'd0;
        slot_done  <= 1'b0;
        frame_done <= 1'b0;
      end
    end
  end

endmodule
